// File: rtl/ysyx_25040111_mem_ctrl_if.sv
// Memory-stage bus bundle: execute-side request, write-back result and
// the single-beat LSU read/write channels.
//
// Handshake semantics (all channels): a transfer happens on a rising clock
// edge where both valid and ready are 1. in_* and out_* are classic
// valid/ready channels. lsu_rvalid/lsu_wvalid are one-cycle request pulses;
// lsu_rready/lsu_wready are one-cycle completion strobes from the LSU, and
// lsu_rdata is only meaningful in the lsu_rready cycle.
interface ysyx_25040111_mem_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic [31:0] in_result;
  logic        in_load;
  logic        in_store;
  logic [1:0]  in_mask;
  logic        in_sign;
  logic [31:0] in_wdata;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic [31:0] out_result;
  logic        out_exc;
  logic [3:0]  out_exc_cause;

  logic        lsu_rvalid;
  logic        lsu_rready;
  logic [31:0] lsu_rdata;
  logic [31:0] lsu_raddr;
  logic [7:0]  lsu_rlen;
  logic        lsu_burst;
  logic        lsu_rsign;
  logic [1:0]  lsu_rmask;
  logic        lsu_wvalid;
  logic        lsu_wready;
  logic [31:0] lsu_wdata;
  logic [31:0] lsu_waddr;
  logic [1:0]  lsu_wmask;

  // Environment side: execute stage, write-back and LSU.
  modport master (
    output in_valid, in_pc, in_rd, in_rd_wen, in_result, in_load, in_store,
           in_mask, in_sign, in_wdata, out_ready, lsu_rready, lsu_rdata,
           lsu_wready,
    input  in_ready, out_valid, out_pc, out_rd, out_rd_wen, out_result,
           out_exc, out_exc_cause, lsu_rvalid, lsu_raddr, lsu_rlen,
           lsu_burst, lsu_rsign, lsu_rmask, lsu_wvalid, lsu_wdata,
           lsu_waddr, lsu_wmask
  );

  // Controller side.
  modport slave (
    input  in_valid, in_pc, in_rd, in_rd_wen, in_result, in_load, in_store,
           in_mask, in_sign, in_wdata, out_ready, lsu_rready, lsu_rdata,
           lsu_wready,
    output in_ready, out_valid, out_pc, out_rd, out_rd_wen, out_result,
           out_exc, out_exc_cause, lsu_rvalid, lsu_raddr, lsu_rlen,
           lsu_burst, lsu_rsign, lsu_rmask, lsu_wvalid, lsu_wdata,
           lsu_waddr, lsu_wmask
  );
endinterface

// File: rtl/ysyx_25040111_mem_ctrl.sv
// Memory-stage controller: accepts one instruction, issues at most one LSU
// read or write pulse, traps misaligned accesses locally and hands the
// finished result to write-back. All outputs come straight from registers.
module ysyx_25040111_mem_ctrl #(
  parameter logic [3:0] EXC_LD_MISALIGN = 4'd4,
  parameter logic [3:0] EXC_ST_MISALIGN = 4'd6
) (
  input  logic                          clock,
  input  logic                          reset,
  ysyx_25040111_mem_ctrl_if.slave       bus,
  output logic [2:0]                    dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        rvalid_q;
  logic        wvalid_q;
  logic [31:0] pc_q;
  logic [4:0]  rd_q;
  logic        rd_wen_q;
  logic [31:0] result_q;
  logic [1:0]  mask_q;
  logic        sign_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        exc_q;
  logic [3:0]  cause_q;

  logic acc_load;
  logic acc_store;
  logic acc_mis;

  // Decode the incoming instruction's class and alignment.
  always_comb begin
    acc_load  = bus.in_load && (bus.in_mask != 2'b00);
    acc_store = !acc_load && bus.in_store && (bus.in_mask != 2'b00);
    acc_mis   = ((bus.in_mask == 2'b10) && bus.in_result[0]) ||
                ((bus.in_mask == 2'b11) && (bus.in_result[1:0] != 2'b00));
  end

  // Transaction FSM with all outputs and latched fields registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      rvalid_q    <= 1'b0;
      wvalid_q    <= 1'b0;
      pc_q        <= '0;
      rd_q        <= '0;
      rd_wen_q    <= 1'b0;
      result_q    <= '0;
      mask_q      <= '0;
      sign_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      exc_q       <= 1'b0;
      cause_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            pc_q       <= bus.in_pc;
            rd_q       <= bus.in_rd;
            result_q   <= bus.in_result;
            addr_q     <= bus.in_result;
            mask_q     <= bus.in_mask;
            sign_q     <= bus.in_sign;
            wdata_q    <= bus.in_wdata;
            if ((acc_load || acc_store) && acc_mis) begin
              // Misaligned: trap without touching the bus.
              rd_wen_q    <= 1'b0;
              exc_q       <= 1'b1;
              cause_q     <= acc_load ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              rd_wen_q <= bus.in_rd_wen;
              exc_q    <= 1'b0;
              cause_q  <= '0;
              if (acc_load) begin
                rvalid_q <= 1'b1;
                state    <= RD_REQ;
              end else if (acc_store) begin
                wvalid_q <= 1'b1;
                state    <= WR_REQ;
              end else begin
                out_valid_q <= 1'b1;
                state       <= DONE;
              end
            end
          end
        end
        RD_REQ, RD_WAIT: begin
          rvalid_q <= 1'b0;
          if (bus.lsu_rready) begin
            result_q    <= bus.lsu_rdata;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            state <= RD_WAIT;
          end
        end
        WR_REQ, WR_WAIT: begin
          wvalid_q <= 1'b0;
          if (bus.lsu_wready) begin
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            state <= WR_WAIT;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          rvalid_q    <= 1'b0;
          wvalid_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_pc        = pc_q;
  assign bus.out_rd        = rd_q;
  assign bus.out_rd_wen    = rd_wen_q;
  assign bus.out_result    = result_q;
  assign bus.out_exc       = exc_q;
  assign bus.out_exc_cause = cause_q;
  assign bus.lsu_rvalid    = rvalid_q;
  assign bus.lsu_raddr     = addr_q;
  assign bus.lsu_rlen      = 8'd0;
  assign bus.lsu_burst     = 1'b0;
  assign bus.lsu_rsign     = sign_q;
  assign bus.lsu_rmask     = mask_q;
  assign bus.lsu_wvalid    = wvalid_q;
  assign bus.lsu_wdata     = wdata_q;
  assign bus.lsu_waddr     = addr_q;
  assign bus.lsu_wmask     = mask_q;
  assign dbg_state         = state;

endmodule

// File: tb/tb_ysyx_25040111_mem_ctrl.sv
// Bench for the memory-stage controller: directed scenarios followed by
// random instructions, with the LSU and write-back emulated in the bench.
module tb_ysyx_25040111_mem_ctrl;

  logic       clock;
  logic       reset;
  logic [2:0] dbg_state;
  int         checks;
  int         failures;
  logic [31:0] exp_q[$];

  ysyx_25040111_mem_ctrl_if bus ();

  ysyx_25040111_mem_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one instruction through accept, LSU service and write-back.
  task automatic run_instr(input logic [31:0] pc, input logic [4:0] rd,
                           input logic rd_wen, input logic [31:0] addr,
                           input logic ld, input logic st, input logic [1:0] mask,
                           input logic sgn, input logic [31:0] wdata,
                           input int delay, input logic [31:0] rdata,
                           input int stall);
    logic        is_load, is_store, mis;
    logic [31:0] exp_res, got_res;
    logic [3:0]  exp_cause;
    int          rp, wp;
    is_load  = ld && (mask != 2'b00);
    is_store = !is_load && st && (mask != 2'b00);
    mis      = (is_load || is_store) &&
               (((mask == 2'b10) && (addr % 2 != 0)) ||
                ((mask == 2'b11) && (addr % 4 != 0)));
    exp_res   = (is_load && !mis) ? rdata : addr;
    exp_cause = mis ? (is_load ? 4'd4 : 4'd6) : 4'd0;
    exp_q.push_back(exp_res);

    chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_pc     = pc;
    bus.in_rd     = rd;
    bus.in_rd_wen = rd_wen;
    bus.in_result = addr;
    bus.in_load   = ld;
    bus.in_store  = st;
    bus.in_mask   = mask;
    bus.in_sign   = sgn;
    bus.in_wdata  = wdata;
    tick();
    bus.in_valid  = 1'b0;
    bus.in_result = 32'h0;
    bus.in_wdata  = 32'h0;
    chk("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);

    rp = 0;
    wp = 0;
    if ((is_load || is_store) && !mis) begin
      for (int k = 0; k <= delay; k++) begin
        if (bus.lsu_rvalid) rp++;
        if (bus.lsu_wvalid) wp++;
        chk("no_early_out", {31'd0, bus.out_valid}, 32'd0);
        chk("addr_stable", is_load ? bus.lsu_raddr : bus.lsu_waddr, addr);
        chk("mask_stable", {30'd0, is_load ? bus.lsu_rmask : bus.lsu_wmask}, {30'd0, mask});
        if (is_load) chk("rsign", {31'd0, bus.lsu_rsign}, {31'd0, sgn});
        else         chk("wdata", bus.lsu_wdata, wdata);
        if (k == delay) begin
          if (is_load) begin
            bus.lsu_rready = 1'b1;
            bus.lsu_rdata  = rdata;
          end else begin
            bus.lsu_wready = 1'b1;
          end
        end
        tick();
        bus.lsu_rready = 1'b0;
        bus.lsu_wready = 1'b0;
        bus.lsu_rdata  = $urandom;
      end
    end
    if (bus.lsu_rvalid) rp++;
    if (bus.lsu_wvalid) wp++;
    chk("rvalid_pulses", rp, (is_load && !mis) ? 1 : 0);
    chk("wvalid_pulses", wp, (is_store && !mis) ? 1 : 0);
    chk("out_valid_latency", {31'd0, bus.out_valid}, 32'd1);

    got_res = bus.out_result;
    chk("out_result", got_res, exp_q.pop_front());
    chk("out_pc", bus.out_pc, pc);
    chk("out_rd", {27'd0, bus.out_rd}, {27'd0, rd});
    chk("out_rd_wen", {31'd0, bus.out_rd_wen}, {31'd0, rd_wen && !mis});
    chk("out_exc", {31'd0, bus.out_exc}, {31'd0, mis});
    chk("out_exc_cause", {28'd0, bus.out_exc_cause}, {28'd0, exp_cause});

    bus.out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      // Stray LSU strobes while waiting on write-back must be ignored.
      bus.lsu_rready = 1'b1;
      bus.lsu_wready = 1'b1;
      tick();
      bus.lsu_rready = 1'b0;
      bus.lsu_wready = 1'b0;
      chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_result", bus.out_result, got_res);
      chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("stall_no_req", {30'd0, bus.lsu_rvalid, bus.lsu_wvalid}, 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("wb_done_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("wb_done_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus.in_valid   = 1'b0;
    bus.in_pc      = '0;
    bus.in_rd      = '0;
    bus.in_rd_wen  = 1'b0;
    bus.in_result  = '0;
    bus.in_load    = 1'b0;
    bus.in_store   = 1'b0;
    bus.in_mask    = '0;
    bus.in_sign    = 1'b0;
    bus.in_wdata   = '0;
    bus.out_ready  = 1'b0;
    bus.lsu_rready = 1'b0;
    bus.lsu_rdata  = '0;
    bus.lsu_wready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_req", {30'd0, bus.lsu_rvalid, bus.lsu_wvalid}, 32'd0);
    chk("rst_result", bus.out_result, 32'd0);
    chk("rst_addr", bus.lsu_raddr, 32'd0);
    chk("rst_exc", {27'd0, bus.out_exc, bus.out_exc_cause}, 32'd0);
    chk("rst_tied", {23'd0, bus.lsu_burst, bus.lsu_rlen}, 32'd0);

    // lw aligned, completion 3 cycles after pulse
    run_instr(32'h8000_0100, 5'd10, 1'b1, 32'h8000_0010, 1'b1, 1'b0, 2'b11, 1'b0,
              32'h0, 3, 32'hDEAD_BEEF, 0);
    // lb signed
    run_instr(32'h8000_0104, 5'd11, 1'b1, 32'h8000_0003, 1'b1, 1'b0, 2'b01, 1'b1,
              32'h0, 1, 32'hFFFF_FF80, 1);
    // sh
    run_instr(32'h8000_0108, 5'd0, 1'b0, 32'h8000_0002, 1'b0, 1'b1, 2'b10, 1'b0,
              32'h0000_1234, 2, 32'h0, 0);
    // misaligned lw and sw
    run_instr(32'h8000_010c, 5'd12, 1'b1, 32'h8000_0006, 1'b1, 1'b0, 2'b11, 1'b0,
              32'h0, 0, 32'h0, 0);
    run_instr(32'h8000_0110, 5'd0, 1'b1, 32'h8000_0006, 1'b0, 1'b1, 2'b11, 1'b0,
              32'h5555_aaaa, 0, 32'h0, 0);
    // load wins over store; completion in the request cycle
    run_instr(32'h8000_0114, 5'd13, 1'b1, 32'h8000_0020, 1'b1, 1'b1, 2'b10, 1'b1,
              32'h9999_0000, 0, 32'h0000_7abc, 0);
    // pass-through with write-back stalled 5 cycles
    run_instr(32'h8000_0118, 5'd14, 1'b1, 32'h0000_0042, 1'b0, 1'b0, 2'b00, 1'b0,
              32'h0, 0, 32'h0, 5);

    // Reset during RD_WAIT
    bus.in_valid  = 1'b1;
    bus.in_result = 32'h8000_0040;
    bus.in_load   = 1'b1;
    bus.in_store  = 1'b0;
    bus.in_mask   = 2'b11;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("midrst_rvalid", {31'd0, bus.lsu_rvalid}, 32'd0);
    bus.lsu_rready = 1'b1;
    bus.lsu_rdata  = 32'hBAD0_BAD0;
    tick();
    bus.lsu_rready = 1'b0;
    chk("stray_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("stray_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("stray_result", bus.out_result, 32'd0);

    // Random instructions
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = $urandom;
      run_instr($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), a,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                $urandom_range(0, 4), $urandom, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_25040111_mem_ctrl.md
Name: ysyx_25040111_mem_ctrl

Overview:
Memory-stage controller between the execute stage and the load/store unit. It accepts one instruction at a time over a valid/ready handshake and issues single-beat read or write requests to the LSU. It holds all request fields stable for the whole transaction, captures load data, and presents the completed result to write-back over a valid/ready handshake. Misaligned accesses are trapped locally and generate no bus traffic.

Parameters:
EXC_LD_MISALIGN, 4, cause code reported for a misaligned load
EXC_ST_MISALIGN, 6, cause code reported for a misaligned store

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
in_valid  in  1  execute-stage instruction valid
in_ready  out  1  controller can accept an instruction
in_pc  in  32  instruction PC
in_rd  in  5  destination register
in_rd_wen  in  1  destination write enable
in_result  in  32  ALU result; effective address for loads and stores
in_load  in  1  instruction is a load
in_store  in  1  instruction is a store
in_mask  in  2  access size: 01 byte, 10 half, 11 word, 00 none
in_sign  in  1  sign-extend load data
in_wdata  in  32  store data, unshifted
out_valid  out  1  result valid to write-back
out_ready  in  1  write-back accepts the result
out_pc  out  32  latched PC
out_rd  out  5  latched rd
out_rd_wen  out  1  latched rd_wen; forced 0 on exception
out_result  out  32  load data for loads, otherwise latched in_result
out_exc  out  1  misalignment exception
out_exc_cause  out  4  cause code; 0 when out_exc=0
lsu_rvalid  out  1  one-cycle read request pulse
lsu_rready  in  1  read complete; lsu_rdata valid in this cycle only
lsu_rdata  in  32  aligned, extended load data
lsu_raddr  out  32  read address
lsu_rlen  out  8  tied 0
lsu_burst  out  1  tied 0
lsu_rsign  out  1  load sign flag
lsu_rmask  out  2  load size
lsu_wvalid  out  1  one-cycle write request pulse
lsu_wready  in  1  write response received
lsu_wdata  out  32  store data
lsu_waddr  out  32  store address
lsu_wmask  out  2  store size

Behaviour:
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
- Reset values:
  - state=IDLE, in_ready=1, all other outputs 0.
  - All latched fields are cleared to 0.
- Handshake rule: in_ready=1 only in IDLE. There is no same-cycle refill from DONE.
- Accept (IDLE, in_valid=1):
  - Latch all in_* fields.
  - Decode class: load if in_load=1 and in_mask!=00; else store if in_store=1 and in_mask!=00; else pass-through. Load wins if both in_load and in_store are set.
- Misalignment: mask 10 with addr[0]=1, or mask 11 with addr[1:0]!=00.
  - Go directly to DONE with out_exc=1, cause EXC_LD_MISALIGN or EXC_ST_MISALIGN, out_rd_wen=0.
  - No lsu_rvalid or lsu_wvalid is issued.
- Next state after accept: aligned load -> RD_REQ; aligned store -> WR_REQ; pass-through -> DONE.
- RD_REQ: lsu_rvalid=1 for exactly one cycle, then RD_WAIT.
- RD_WAIT:
  - Wait for lsu_rready=1.
  - In that cycle, capture lsu_rdata into out_result and go to DONE.
  - A lsu_rready seen in RD_REQ is treated identically.
- WR_REQ / WR_WAIT: same structure using lsu_wvalid and lsu_wready. out_result keeps the latched in_result.
- DONE: out_valid=1; on out_ready=1, go to IDLE.
  - Outputs are held stable while out_ready=0.
  - out_valid deasserts in the cycle after the handshake.
- lsu_raddr, lsu_waddr = latched address; lsu_rmask, lsu_wmask = latched mask; lsu_rsign and lsu_wdata = latched values. These are driven from registers in every state and are stable from RD_REQ/WR_REQ until completion.
- Request pulses: lsu_rvalid and lsu_wvalid are never both 1, and each is at most one cycle per instruction. Any lsu_rready/lsu_wready outside the WAIT/REQ states is ignored.
- Latency (accept in cycle T, LSU completion in cycle C): load/store out_valid at C+1; pass-through and exceptions out_valid at T+1.
- Reset mid-transaction: return to IDLE next cycle and drop the instruction. The LSU shares the same reset.

Test Plan:
- lw, addr 0x8000_0010, mask 11; LSU completes 3 cycles after the pulse with rdata 0xDEADBEEF -> single lsu_rvalid pulse, lsu_raddr stable until completion, out_result=0xDEADBEEF, out_exc=0.
- lb, sign=1, addr 0x8000_0003; LSU returns 0xFFFFFF80 -> lsu_rmask=01, lsu_rsign=1, out_result=0xFFFFFF80, out_rd_wen preserved.
- sh, addr 0x8000_0002, wdata 0x1234 -> one lsu_wvalid pulse, lsu_wmask=10; out_valid the cycle after lsu_wready.
- lw, addr 0x8000_0006 -> no lsu_rvalid, out_valid at T+1, out_exc=1, cause 4, out_rd_wen=0; repeat as a store -> cause 6.
- Pass-through ALU result 0x42 with out_ready held 0 for 5 cycles -> out_valid and out_result stable, in_ready=0, single write-back handshake.
- Assert reset during RD_WAIT -> IDLE, out_valid=0, in_ready=1 next cycle; a later stray lsu_rready is ignored.
